// File: rtl/switch_pkg.sv
// Shared types for the switch receive path: parser state, sync marker and header record.
package switch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DA      = 3'd1,
    ST_SA      = 3'd2,
    ST_LEN     = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_PARITY  = 3'd5
  } rx_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hFF;

  typedef struct packed {
    logic [7:0] da;
    logic [7:0] sa;
    logic [7:0] len;
  } rx_hdr_t;

  // Frame check is a plain running XOR over DA, SA, LEN and payload.
  function automatic logic [7:0] parity_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/switch_rx_stats.sv
// Saturating frame / error counters for the receive parser (built only with SWITCH_RX_PARSER_STATS_EN).
module switch_rx_stats (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        frame_done_i,
  input  logic        frame_err_i,
  output logic [15:0] stat_frames_o,
  output logic [15:0] stat_errs_o
);

  logic [15:0] frames_q, frames_d;
  logic [15:0] errs_q, errs_d;

  // Next-state: increment on a completed frame, holding at all-ones.
  always_comb begin
    frames_d = frames_q;
    errs_d   = errs_q;
    if (frame_done_i && (frames_q != 16'hFFFF)) begin
      frames_d = frames_q + 16'd1;
    end else begin
      frames_d = frames_q;
    end
    if (frame_done_i && frame_err_i && (errs_q != 16'hFFFF)) begin
      errs_d = errs_q + 16'd1;
    end else begin
      errs_d = errs_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frames_q <= 16'h0000;
      errs_q   <= 16'h0000;
    end else begin
      frames_q <= frames_d;
      errs_q   <= errs_d;
    end
  end

  assign stat_frames_o = frames_q;
  assign stat_errs_o   = errs_q;

endmodule

// File: rtl/switch_rx_parser.sv
// Control-port framing stage: sync hunt, header/payload/parity parse, registered byte stream out.
// Optional statistics counters are enabled by defining SWITCH_RX_PARSER_STATS_EN.
module switch_rx_parser
  import switch_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int unsigned MAX_LEN   = 255
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       sw_enable_in,
  output logic       read_out,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_eop,
  output logic       out_err,
  output logic [7:0] hdr_da,
  output logic [7:0] hdr_sa,
  output logic [7:0] hdr_len
`ifdef SWITCH_RX_PARSER_STATS_EN
  ,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_errs
`endif
);

  // LENGTH is 8 bits, so any limit at or above 255 can never trip.
  localparam int unsigned MAX_LEN_CLAMP = (MAX_LEN > 255) ? 255 : MAX_LEN;
  localparam logic [7:0]  MAX_LEN_B     = MAX_LEN_CLAMP[7:0];

  rx_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] par_q, par_d;
  logic       len_err_q, len_err_d;
  rx_hdr_t    hdr_q, hdr_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       out_sop_q, out_sop_d;
  logic       out_eop_q, out_eop_d;
  logic       out_err_q, out_err_d;
  logic       accept_s, fwd_s, sop_s, eop_s, err_s;

  assign read_out = reset_n && (!out_valid_q || out_ready);
  assign accept_s = sw_enable_in && read_out;

  // Frame FSM and output-register next state; a forwarded byte overwrites a drained slot.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    par_d       = par_q;
    len_err_d   = len_err_q;
    hdr_d       = hdr_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_err_d   = out_err_q;
    fwd_s       = 1'b0;
    sop_s       = 1'b0;
    eop_s       = 1'b0;
    err_s       = 1'b0;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (accept_s) begin
      case (state_q)
        ST_IDLE: begin
          if (data_in == SYNC_BYTE) begin
            state_d = ST_DA;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DA: begin
          fwd_s     = 1'b1;
          sop_s     = 1'b1;
          hdr_d.da  = data_in;
          par_d     = data_in;
          len_err_d = 1'b0;
          state_d   = ST_SA;
        end
        ST_SA: begin
          fwd_s    = 1'b1;
          hdr_d.sa = data_in;
          par_d    = parity_step(par_q, data_in);
          state_d  = ST_LEN;
        end
        ST_LEN: begin
          fwd_s     = 1'b1;
          hdr_d.len = data_in;
          par_d     = parity_step(par_q, data_in);
          len_err_d = (data_in > MAX_LEN_B);
          if (data_in == 8'h00) begin
            cnt_d   = 8'h00;
            state_d = ST_PARITY;
          end else begin
            cnt_d   = data_in;
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          fwd_s = 1'b1;
          par_d = parity_step(par_q, data_in);
          if (cnt_q > 8'd1) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            cnt_d   = 8'h00;
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          fwd_s   = 1'b1;
          eop_s   = 1'b1;
          err_s   = (data_in != par_q) || len_err_q;
          cnt_d   = 8'h00;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (fwd_s) begin
      out_data_d  = data_in;
      out_valid_d = 1'b1;
      out_sop_d   = sop_s;
      out_eop_d   = eop_s;
      out_err_d   = err_s;
    end else begin
      out_data_d  = out_data_q;
    end
  end

  // State, header and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'h00;
      par_q       <= 8'h00;
      len_err_q   <= 1'b0;
      hdr_q       <= '{da: 8'h00, sa: 8'h00, len: 8'h00};
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      len_err_q   <= len_err_d;
      hdr_q       <= hdr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_err   = out_err_q;
  assign hdr_da    = hdr_q.da;
  assign hdr_sa    = hdr_q.sa;
  assign hdr_len   = hdr_q.len;

`ifdef SWITCH_RX_PARSER_STATS_EN
  logic frame_done_s;
  assign frame_done_s = accept_s && (state_q == ST_PARITY);

  switch_rx_stats u_stats (
    .clock         (clock),
    .reset_n       (reset_n),
    .frame_done_i  (frame_done_s),
    .frame_err_i   (err_s),
    .stat_frames_o (stat_frames),
    .stat_errs_o   (stat_errs)
  );
`endif

endmodule

// File: tb/tb_switch_rx_parser.sv
// Scoreboard bench for switch_rx_parser: frames are modelled at byte level, forwarded bytes queued and compared.
module tb_switch_rx_parser;

  logic       clock;
  logic       reset_n;
  logic [7:0] data_in;
  logic       sw_enable_in;
  logic       read_out;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sop;
  logic       out_eop;
  logic       out_err;
  logic [7:0] hdr_da;
  logic [7:0] hdr_sa;
  logic [7:0] hdr_len;
`ifdef SWITCH_RX_PARSER_STATS_EN
  logic [15:0] stat_frames;
  logic [15:0] stat_errs;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] pl_q[$];
  int         n_pass = 0;
  int         n_total = 0;
  int         exp_frames = 0;
  int         exp_errs = 0;

  switch_rx_parser dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .sw_enable_in (sw_enable_in),
    .read_out     (read_out),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_err      (out_err),
    .hdr_da       (hdr_da),
    .hdr_sa       (hdr_sa),
    .hdr_len      (hdr_len)
`ifdef SWITCH_RX_PARSER_STATS_EN
    ,
    .stat_frames  (stat_frames),
    .stat_errs    (stat_errs)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard monitor: a byte transfers at the next rising edge when valid && ready.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL stream_unexpected: got data=%h sop=%b eop=%b err=%b, required no byte",
                 out_data, out_sop, out_eop, out_err);
      end else begin
        mon_e = sb.pop_front();
        if ({out_data, out_sop, out_eop, out_err} !== {mon_e.d, mon_e.sop, mon_e.eop, mon_e.err})
          $display("FAIL stream_byte: got data=%h sop=%b eop=%b err=%b, required data=%h sop=%b eop=%b err=%b",
                   out_data, out_sop, out_eop, out_err, mon_e.d, mon_e.sop, mon_e.eop, mon_e.err);
        else
          n_pass++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit fwd, input bit sop, input bit eop, input bit err);
    bit acc;
    int guard;
    data_in = b;
    sw_enable_in = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 100) begin
      @(negedge clock);
      acc = read_out;
      guard++;
      @(posedge clock);
      #1;
    end
    if (!acc) begin
      n_total++;
      $display("FAIL accept_timeout: byte %h got no read_out, required acceptance", b);
    end else if (fwd) begin
      sb.push_back('{d: b, sop: sop, eop: eop, err: err});
    end
    sw_enable_in = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    sw_enable_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Sync, header, payload from pl_q, parity and a trailing 00; expected error from the bench's own XOR.
  task automatic send_frame(input logic [7:0] da, input logic [7:0] sa, input logic [7:0] len,
                            input logic [7:0] par, input bit stall);
    logic [7:0] x;
    bit e;
    x = da ^ sa ^ len;
    foreach (pl_q[i]) x = x ^ pl_q[i];
    e = (par !== x);
    send_byte(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(da, 1'b1, 1'b1, 1'b0, 1'b0);
    send_byte(sa, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(len, 1'b1, 1'b0, 1'b0, 1'b0);
    foreach (pl_q[i]) begin
      send_byte(pl_q[i], 1'b1, 1'b0, 1'b0, 1'b0);
      if (stall) idle_cycles(1);
    end
    send_byte(par, 1'b1, 1'b0, 1'b1, e);
    exp_frames++;
    if (e) exp_errs++;
    send_byte(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain_check(input string name);
    idle_cycles(4);
    n_total++;
    if (sb.size() != 0)
      $display("FAIL %s_drain: got %0d bytes still expected, required 0", name, sb.size());
    else
      n_pass++;
`ifdef SWITCH_RX_PARSER_STATS_EN
    n_total++;
    if (stat_frames !== 16'(exp_frames) || stat_errs !== 16'(exp_errs))
      $display("FAIL %s_stats: got frames=%0d errs=%0d, required frames=%0d errs=%0d",
               name, stat_frames, stat_errs, exp_frames, exp_errs);
    else
      n_pass++;
`endif
  endtask

  task automatic check_hdr(input string name, input logic [7:0] da, input logic [7:0] sa, input logic [7:0] len);
    n_total++;
    if ({hdr_da, hdr_sa, hdr_len} !== {da, sa, len})
      $display("FAIL %s_hdr: got %h/%h/%h, required %h/%h/%h", name, hdr_da, hdr_sa, hdr_len, da, sa, len);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    data_in = 8'h00;
    sw_enable_in = 1'b0;
    out_ready = 1'b1;
    #23;
    n_total++;
    if ({read_out, out_valid, out_sop, out_eop, out_err, out_data, hdr_da, hdr_sa, hdr_len} !== 29'd0)
      $display("FAIL reset_values: got rd=%b v=%b data=%h hdr=%h/%h/%h, required all zero",
               read_out, out_valid, out_data, hdr_da, hdr_sa, hdr_len);
    else
      n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    n_total++;
    if (read_out !== 1'b1)
      $display("FAIL reset_release_read: got %b, required 1", read_out);
    else
      n_pass++;
  endtask

  task automatic test_nominal();
    pl_q = '{8'h10, 8'h20, 8'h30};
    send_frame(8'h01, 8'h02, 8'h03, 8'h00, 1'b0);
    drain_check("nominal");
    check_hdr("nominal", 8'h01, 8'h02, 8'h03);
  endtask

  task automatic test_bad_parity();
    pl_q = '{8'h10, 8'h20, 8'h30};
    send_frame(8'h01, 8'h02, 8'h03, 8'h55, 1'b0);
    drain_check("bad_parity");
    pl_q = '{8'h10, 8'h20, 8'h30};
    send_frame(8'h01, 8'h02, 8'h03, 8'h02, 1'b0);
    drain_check("parity_02");
  endtask

  task automatic test_len_zero();
    pl_q.delete();
    send_frame(8'h0A, 8'h0B, 8'h00, 8'h01, 1'b0);
    drain_check("len_zero");
    check_hdr("len_zero", 8'h0A, 8'h0B, 8'h00);
  endtask

  task automatic test_enable_stall();
    pl_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(8'hA1, 8'hB2, 8'h04, 8'hA1 ^ 8'hB2 ^ 8'h04 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 1'b1);
    drain_check("enable_stall");
  endtask

  task automatic test_backpressure();
    send_byte(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h0C, 1'b1, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
    data_in = 8'h0D;
    sw_enable_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_total++;
      if (read_out !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h0C)
        $display("FAIL backpressure_hold: got rd=%b v=%b data=%h, required rd=0 v=1 data=0c",
                 read_out, out_valid, out_data);
      else
        n_pass++;
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    send_byte(8'h0D, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h0C ^ 8'h0D ^ 8'h01 ^ 8'h77, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_frames++;
    drain_check("backpressure");
    check_hdr("backpressure", 8'h0C, 8'h0D, 8'h01);
  endtask

  task automatic test_garbage_and_resync();
    send_byte(8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
    pl_q = '{8'hFF, 8'h5A};
    send_frame(8'h21, 8'h22, 8'h02, 8'h21 ^ 8'h22 ^ 8'h02 ^ 8'hFF ^ 8'h5A, 1'b0);
    drain_check("garbage");
    check_hdr("garbage", 8'h21, 8'h22, 8'h02);
  endtask

  task automatic test_back_to_back();
    pl_q = '{8'h01};
    send_frame(8'h31, 8'h32, 8'h01, 8'h31 ^ 8'h32 ^ 8'h01 ^ 8'h01, 1'b0);
    pl_q = '{8'hC0, 8'hDE};
    send_frame(8'h41, 8'h42, 8'h02, 8'h99, 1'b0);
    drain_check("back_to_back");
    check_hdr("back_to_back", 8'h41, 8'h42, 8'h02);
  endtask

  task automatic test_reset_mid_payload();
    send_byte(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h51, 1'b1, 1'b1, 1'b0, 1'b0);
    send_byte(8'h52, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({read_out, out_valid, out_sop, out_eop, out_err, out_data, hdr_da, hdr_sa, hdr_len} !== 29'd0)
      $display("FAIL midreset_values: got rd=%b v=%b data=%h hdr=%h/%h/%h, required all zero",
               read_out, out_valid, out_data, hdr_da, hdr_sa, hdr_len);
    else
      n_pass++;
    sb.delete();
    exp_frames = 0;
    exp_errs = 0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    pl_q = '{8'h10, 8'h20, 8'h30};
    send_frame(8'h01, 8'h02, 8'h03, 8'h00, 1'b0);
    drain_check("midreset");
    check_hdr("midreset", 8'h01, 8'h02, 8'h03);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_parity();
    test_len_zero();
    test_enable_stall();
    test_backpressure();
    test_garbage_and_resync();
    test_back_to_back();
    test_reset_mid_payload();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
